// File: rtl/clk_pkg.sv
// Shared definitions for the clock measurement blocks.
//   DEFAULT_CNT_W   : default width of tick counters and count outputs
//   DEFAULT_TIMEOUT : default stall timeout in inclk ticks (1 s at 50 MHz)
//   meter_state_t   : clock_period_meter FSM states
package clk_pkg;

  localparam int DEFAULT_CNT_W   = 32;
  localparam int DEFAULT_TIMEOUT = 50_000_000;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a history flop for edge detection.
// Reusable for slow asynchronous inputs (measured clocks, buttons, keys).
// Ports:
//   inclk   : system clock
//   Reset   : asynchronous active-high reset, clears all three flops
//   sig_in  : asynchronous input
//   s_level : synchronized level
//   rise    : one-cycle pulse on a synchronized 0->1 transition
//   fall    : one-cycle pulse on a synchronized 1->0 transition
module sync_edge_detect (
  input  logic inclk,
  input  logic Reset,
  input  logic sig_in,
  output logic s_level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge inclk or posedge Reset) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign s_level = s2;
  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;

endmodule

// File: rtl/clock_period_meter.sv
// Measures high time, low time and period of a slow asynchronous square
// wave in inclk ticks, and reports the matching clock_divider half-period
// setting (each divider phase lasts div_clk_count+1 ticks).
// Ports:
//   inclk          : system clock (CLK_50M)
//   Reset          : asynchronous active-high reset
//   enable         : measurement enable; 0 holds the FSM in ARM
//   sig_in         : asynchronous signal under measurement
//   high_count     : ticks high in the last complete cycle
//   low_count      : ticks low in the last complete cycle
//   period_count   : high_count + low_count
//   half_div_count : high_count - 1
//   symmetric      : high_count == low_count
//   meas_valid     : one-cycle pulse, aligned with the count update
//   stalled        : no expected edge within TIMEOUT_CYCLES
//
// state | meaning
// ------+-----------------------------------------------------------
// ARM   | idle, waiting for a rising edge to start a measurement
// HIGH  | counting the high phase, waiting for the falling edge
// LOW   | counting the low phase, waiting for the closing rising edge
module clock_period_meter
  import clk_pkg::*;
#(
  parameter int CNT_W          = DEFAULT_CNT_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic             inclk,
  input  logic             Reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_count,
  output logic [CNT_W-1:0] low_count,
  output logic [CNT_W-1:0] period_count,
  output logic [CNT_W-1:0] half_div_count,
  output logic             symmetric,
  output logic             meas_valid,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  meter_state_t     state;
  meter_state_t     state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_tmp;
  logic             rise;
  logic             fall;
  logic             s_level_unused;
  logic             at_tmo;

  logic cnt_start;
  logic hi_latch;
  logic meas_load;
  logic timeout;

  sync_edge_detect u_sync (
    .inclk   (inclk),
    .Reset   (Reset),
    .sig_in  (sig_in),
    .s_level (s_level_unused),
    .rise    (rise),
    .fall    (fall)
  );

  // The counter stops at TMO, so it can never wrap.
  assign at_tmo = (cnt == TMO);

  always_ff @(posedge inclk or posedge Reset) begin
    if (Reset) state <= ARM;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARM:  if (enable && rise) state_next = HIGH;
      HIGH: begin
        if (!enable)     state_next = ARM;
        else if (fall)   state_next = LOW;
        else if (at_tmo) state_next = ARM;
      end
      LOW: begin
        if (!enable)     state_next = ARM;
        else if (rise)   state_next = HIGH;
        else if (at_tmo) state_next = ARM;
      end
      default: state_next = ARM;
    endcase
  end

  // An edge arriving on the same cycle as the timeout still wins, so a
  // phase of exactly TIMEOUT_CYCLES ticks is a valid measurement.
  always_comb begin
    cnt_start = 1'b0;
    hi_latch  = 1'b0;
    meas_load = 1'b0;
    timeout   = 1'b0;
    case (state)
      ARM: cnt_start = enable & rise;
      HIGH: if (enable) begin
        if (fall) begin
          hi_latch  = 1'b1;
          cnt_start = 1'b1;
        end else if (at_tmo) begin
          timeout = 1'b1;
        end
      end
      LOW: if (enable) begin
        if (rise) begin
          meas_load = 1'b1;
          cnt_start = 1'b1;
        end else if (at_tmo) begin
          timeout = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge inclk or posedge Reset) begin
    if (Reset) begin
      cnt    <= '0;
      hi_tmp <= '0;
    end else begin
      if (cnt_start)              cnt <= CNT_W'(1);
      else if (state_next == ARM) cnt <= '0;
      else                        cnt <= cnt + CNT_W'(1);
      if (hi_latch) hi_tmp <= cnt;
    end
  end

  // Outputs are registered so meas_valid lands on the same cycle as the
  // new counts.
  always_ff @(posedge inclk or posedge Reset) begin
    if (Reset) begin
      high_count     <= '0;
      low_count      <= '0;
      period_count   <= '0;
      half_div_count <= '0;
      symmetric      <= 1'b0;
      meas_valid     <= 1'b0;
      stalled        <= 1'b0;
    end else begin
      meas_valid <= meas_load;
      if (meas_load) begin
        high_count     <= hi_tmp;
        low_count      <= cnt;
        period_count   <= hi_tmp + cnt;
        half_div_count <= hi_tmp - CNT_W'(1);
        symmetric      <= (hi_tmp == cnt);
        stalled        <= 1'b0;
      end else if (timeout) begin
        stalled <= 1'b1;
      end
    end
  end

endmodule
